// File: rtl/led_run_sched.sv
// Running-light step scheduler: one shared dwell timebase steps N_LED outputs through
// rotate, ping-pong, fill and blink patterns under run/pause/single-step control.
module led_run_sched #(
   parameter int N_LED     = 4,
   parameter int CNT_W     = 16,
   parameter int DWELL_DEF = 250,
   localparam int PW       = $clog2(N_LED)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             En,
   input  logic             Clear,
   input  logic             Dir,
   input  logic [1:0]       Mode,
   input  logic [CNT_W-1:0] Dwell_In,
   input  logic             Dwell_Load,
   input  logic             Step_Req,
   output logic [N_LED-1:0] LED_Out,
   output logic             Step_Done,
   output logic             Running,
   output logic [PW-1:0]    Pos
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
   typedef enum logic [1:0] {
      M_ROTATE = 2'b00,
      M_PING   = 2'b01,
      M_FILL   = 2'b10,
      M_BLINK  = 2'b11
   } mode_t;

   localparam logic [PW-1:0] LAST = PW'(N_LED - 1);

   state_t           state;
   logic [CNT_W-1:0] dwell, cnt, dwell_eff;
   logic [1:0]       mode_q;
   logic             dir_q, blink_q, pp_dir_q;

   logic             boundary, restart, take_step, count_up;
   logic [PW-1:0]    pos_inc, pos_dec, start_pos, nxt_pos;
   logic             nxt_blink, nxt_pp;
   logic [N_LED-1:0] start_led, nxt_led;

   function automatic logic [N_LED-1:0] pattern(input logic [1:0] m, input logic d,
                                                input logic [PW-1:0] p, input logic b);
      logic [N_LED-1:0] v;
      v = '0;
      for (int i = 0; i < N_LED; i++) begin
         case (m)
            M_FILL:  v[i] = d ? (i >= int'(p)) : (i <= int'(p));
            M_BLINK: v[i] = b;
            default: v[i] = (i == int'(p));
         endcase
      end
      return v;
   endfunction

   // NOTE: every signal gets a default at the top of always_comb so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      dwell_eff = (dwell == '0) ? CNT_W'(1) : dwell;
      boundary  = (cnt == dwell_eff - 1'b1);
      pos_inc   = (Pos == LAST) ? '0 : Pos + 1'b1;
      pos_dec   = (Pos == '0) ? LAST : Pos - 1'b1;
      start_pos = Dir ? LAST : '0;
      start_led = pattern(Mode, Dir, start_pos, 1'b1);
      restart   = (Mode != mode_q) || (Dir != dir_q);
      nxt_pos   = Pos;
      nxt_blink = blink_q;
      nxt_pp    = pp_dir_q;

      // A changed Mode/Dir at a step boundary jumps to the new start instead of advancing.
      if (restart) begin
         nxt_pos   = start_pos;
         nxt_blink = 1'b1;
         nxt_pp    = Dir;
      end else begin
         case (mode_q)
            M_ROTATE, M_FILL: nxt_pos = dir_q ? pos_dec : pos_inc;
            M_PING: begin
               if (!pp_dir_q) begin
                  nxt_pos = (Pos == LAST) ? pos_dec : pos_inc;
                  nxt_pp  = (Pos == LAST);
               end else begin
                  nxt_pos = (Pos == '0) ? pos_inc : pos_dec;
                  nxt_pp  = (Pos != '0);
               end
            end
            default: nxt_blink = ~blink_q;
         endcase
      end
      nxt_led = pattern(Mode, Dir, nxt_pos, nxt_blink);

      // PAUSE with En high behaves as RUN on that edge; RUN with En low still finishes a boundary.
      take_step = 1'b0;
      count_up  = 1'b0;
      case (state)
         RUN: begin
            take_step = boundary;
            count_up  = En && !boundary;
         end
         PAUSE: begin
            if (En) begin
               take_step = boundary;
               count_up  = !boundary;
            end else begin
               take_step = Step_Req;
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from
   // the same pre-edge values regardless of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         LED_Out   <= '0;
         Step_Done <= 1'b0;
         Running   <= 1'b0;
         Pos       <= '0;
         dwell     <= CNT_W'(DWELL_DEF);
         cnt       <= '0;
         blink_q   <= 1'b1;
         pp_dir_q  <= 1'b0;
         mode_q    <= 2'b00;
         dir_q     <= 1'b0;
      end else begin
         Step_Done <= 1'b0;
         if (Clear) begin
            state    <= IDLE;
            LED_Out  <= '0;
            Running  <= 1'b0;
            Pos      <= '0;
            cnt      <= '0;
            blink_q  <= 1'b1;
            pp_dir_q <= 1'b0;
            mode_q   <= 2'b00;
            dir_q    <= 1'b0;
         end else if (Dwell_Load) begin
            dwell <= Dwell_In;
            cnt   <= '0;
         end else if (state == IDLE) begin
            if (En) begin
               state    <= RUN;
               Running  <= 1'b1;
               Pos      <= start_pos;
               LED_Out  <= start_led;
               cnt      <= '0;
               mode_q   <= Mode;
               dir_q    <= Dir;
               blink_q  <= 1'b1;
               pp_dir_q <= Dir;
            end
         end else begin
            if (take_step) begin
               Pos       <= nxt_pos;
               LED_Out   <= nxt_led;
               blink_q   <= nxt_blink;
               pp_dir_q  <= nxt_pp;
               mode_q    <= Mode;
               dir_q     <= Dir;
               cnt       <= '0;
               Step_Done <= 1'b1;
            end else if (count_up) begin
               cnt <= cnt + 1'b1;
            end
            state   <= En ? RUN : PAUSE;
            Running <= En;
         end
      end
   end

endmodule
